// File: rtl/common.sv
// rtl/common.sv - shared arbiter state type, memory-bus constants and request record
package common;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  localparam logic [2:0] MEM_SIZE_WORD = 3'b010;

  // One memory-bus request as held for the whole transaction
  typedef struct packed {
    logic        is_write;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } mreq_t;

  function automatic logic [31:0] word_sel(input logic [63:0] dword, input logic hi);
    return hi ? dword[63:32] : dword[31:0];
  endfunction

endpackage

// File: rtl/idbus_arbiter_if.sv
// rtl/idbus_arbiter_if.sv - ibus/dbus requester and shared memory-bus signal bundle
interface idbus_arbiter_if;

  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;

  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;

  logic        mreq_valid;
  logic        mreq_is_write;
  logic [63:0] mreq_addr;
  logic [2:0]  mreq_size;
  logic [7:0]  mreq_strobe;
  logic [63:0] mreq_data;
  logic        mresp_data_ok;
  logic [63:0] mresp_data;

  // Arbiter side
  modport slave (
    input  ireq_valid, ireq_addr,
    input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    input  mresp_data_ok, mresp_data,
    output iresp_addr_ok, iresp_data_ok, iresp_data,
    output dresp_addr_ok, dresp_data_ok, dresp_data,
    output mreq_valid, mreq_is_write, mreq_addr, mreq_size, mreq_strobe, mreq_data
  );

  // Core / memory side
  modport master (
    output ireq_valid, ireq_addr,
    output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    output mresp_data_ok, mresp_data,
    input  iresp_addr_ok, iresp_data_ok, iresp_data,
    input  dresp_addr_ok, dresp_data_ok, dresp_data,
    input  mreq_valid, mreq_is_write, mreq_addr, mreq_size, mreq_strobe, mreq_data
  );

endinterface

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - combinational ibus/dbus winner select
// ARB_ROUND_ROBIN_EN: alternate on ties; otherwise dbus priority with starvation limit
module arb_pick #(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic             ireq_valid,
  input  logic             dreq_valid,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic             last_d,
`else
  input  logic [CNT_W-1:0] starve_cnt,
`endif
  output logic             pick_i,
  output logic             pick_d
);

  always_comb begin
    pick_i = 1'b0;
    pick_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    // last_d clears at reset, so the first tie goes to dbus
    if (ireq_valid && dreq_valid) begin
      pick_d = !last_d;
      pick_i = last_d;
    end else begin
      pick_i = ireq_valid;
      pick_d = dreq_valid;
    end
`else
    if (ireq_valid && (!dreq_valid || (starve_cnt >= CNT_W'(STARVE_LIMIT)))) begin
      pick_i = 1'b1;
    end else begin
      pick_d = dreq_valid;
    end
`endif
  end

endmodule

// File: rtl/idbus_arbiter.sv
// rtl/idbus_arbiter.sv - arbitrates ibus fetches and dbus accesses onto one memory bus
// ARB_ROUND_ROBIN_EN selects round-robin arbitration instead of dbus priority
module idbus_arbiter
  import common::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic           clk,
  input  logic           reset,
  idbus_arbiter_if.slave bus
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  arb_state_t state_q, state_d;
  mreq_t      req_q, req_d;
  logic       pick_i, pick_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d_q, last_d_d;
`else
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
`endif

  arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_arb_pick (
    .ireq_valid (bus.ireq_valid),
    .dreq_valid (bus.dreq_valid),
`ifdef ARB_ROUND_ROBIN_EN
    .last_d     (last_d_q),
`else
    .starve_cnt (starve_cnt_q),
`endif
    .pick_i     (pick_i),
    .pick_d     (pick_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      req_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q <= 1'b0;
`else
      starve_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q <= last_d_d;
`else
      starve_cnt_q <= starve_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d_d = last_d_q;
`else
    starve_cnt_d = starve_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_d         = BUSY_D;
          req_d.is_write  = |bus.dreq_strobe;
          req_d.addr      = bus.dreq_addr;
          req_d.size      = bus.dreq_size;
          req_d.strobe    = bus.dreq_strobe;
          req_d.data      = bus.dreq_data;
`ifdef ARB_ROUND_ROBIN_EN
          last_d_d = 1'b1;
`else
          // Counts only grants that made a waiting ibus wait longer; saturates
          if (bus.ireq_valid && (starve_cnt_q < CNT_W'(STARVE_LIMIT))) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
          end
`endif
        end else if (pick_i) begin
          state_d         = BUSY_I;
          req_d.is_write  = 1'b0;
          req_d.addr      = bus.ireq_addr;
          req_d.size      = MEM_SIZE_WORD;
          req_d.strobe    = '0;
          req_d.data      = '0;
`ifdef ARB_ROUND_ROBIN_EN
          last_d_d = 1'b0;
`else
          starve_cnt_d = '0;
`endif
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus.mresp_data_ok) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend only on state and the latched request, never on live requester inputs
  always_comb begin
    bus.mreq_valid    = 1'b0;
    bus.mreq_is_write = 1'b0;
    bus.mreq_addr     = '0;
    bus.mreq_size     = '0;
    bus.mreq_strobe   = '0;
    bus.mreq_data     = '0;
    bus.iresp_addr_ok = 1'b0;
    bus.iresp_data_ok = 1'b0;
    bus.iresp_data    = '0;
    bus.dresp_addr_ok = 1'b0;
    bus.dresp_data_ok = 1'b0;
    bus.dresp_data    = '0;
    if (state_q != IDLE) begin
      bus.mreq_valid    = 1'b1;
      bus.mreq_is_write = req_q.is_write;
      bus.mreq_addr     = req_q.addr;
      bus.mreq_size     = req_q.size;
      bus.mreq_strobe   = req_q.strobe;
      bus.mreq_data     = req_q.data;
    end
    if (state_q == BUSY_I) begin
      bus.iresp_addr_ok = bus.mresp_data_ok;
      bus.iresp_data_ok = bus.mresp_data_ok;
      bus.iresp_data    = word_sel(bus.mresp_data, req_q.addr[2]);
    end
    if (state_q == BUSY_D) begin
      bus.dresp_addr_ok = bus.mresp_data_ok;
      bus.dresp_data_ok = bus.mresp_data_ok;
      bus.dresp_data    = bus.mresp_data;
    end
  end

endmodule

// File: tb/tb_idbus_arbiter.sv
// tb/tb_idbus_arbiter.sv - directed table-driven bench for idbus_arbiter
// Expected grant order follows ARB_ROUND_ROBIN_EN when defined
module tb_idbus_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  idbus_arbiter_if bus ();

  idbus_arbiter #(.STARVE_LIMIT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        iv;
    logic [63:0] ia;
    logic        dv;
    logic [63:0] da;
    logic [2:0]  dsz;
    logic [7:0]  dstb;
    logic [63:0] dd;
    logic [63:0] mdata;
    int          wait_cyc;
    logic        exp_d;
    logic        exp_wr;
    logic [63:0] exp_addr;
    logic [2:0]  exp_size;
    logic [7:0]  exp_strb;
    logic [63:0] exp_data;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.ireq_valid    = 1'b0;
    bus.ireq_addr     = '0;
    bus.dreq_valid    = 1'b0;
    bus.dreq_addr     = '0;
    bus.dreq_size     = '0;
    bus.dreq_strobe   = '0;
    bus.dreq_data     = '0;
    bus.mresp_data_ok = 1'b0;
    bus.mresp_data    = '0;
  endtask

  task automatic run_txn(input vec_t v, input int idx);
    bus.ireq_valid  = v.iv;
    bus.ireq_addr   = v.ia;
    bus.dreq_valid  = v.dv;
    bus.dreq_addr   = v.da;
    bus.dreq_size   = v.dsz;
    bus.dreq_strobe = v.dstb;
    bus.dreq_data   = v.dd;
    #1;
    chk($sformatf("v%0d_idle_mreq_valid", idx), bus.mreq_valid, 0);
    tick();
    chk($sformatf("v%0d_mreq_valid", idx), bus.mreq_valid, 1);
    chk($sformatf("v%0d_mreq_addr", idx), bus.mreq_addr, v.exp_addr);
    chk($sformatf("v%0d_mreq_is_write", idx), bus.mreq_is_write, v.exp_wr);
    chk($sformatf("v%0d_mreq_size", idx), bus.mreq_size, v.exp_size);
    chk($sformatf("v%0d_mreq_strobe", idx), bus.mreq_strobe, v.exp_strb);
    chk($sformatf("v%0d_mreq_data", idx), bus.mreq_data, v.exp_data);
    // Requester inputs change while busy; the bus request must not follow them
    bus.dreq_addr = ~v.da;
    bus.dreq_data = ~v.dd;
    bus.ireq_addr = ~v.ia;
    for (int c = 0; c < v.wait_cyc; c++) begin
      tick();
      chk($sformatf("v%0d_c%0d_addr_stable", idx, c), bus.mreq_addr, v.exp_addr);
      chk($sformatf("v%0d_c%0d_data_stable", idx, c), bus.mreq_data, v.exp_data);
      chk($sformatf("v%0d_c%0d_no_early_ok", idx, c),
          {bus.iresp_data_ok, bus.dresp_data_ok}, 0);
    end
    bus.mresp_data    = v.mdata;
    bus.mresp_data_ok = 1'b1;
    #1;
    if (v.exp_d) begin
      chk($sformatf("v%0d_dresp_ok", idx), {bus.dresp_addr_ok, bus.dresp_data_ok}, 2'b11);
      chk($sformatf("v%0d_dresp_data", idx), bus.dresp_data, v.exp_rdata);
      chk($sformatf("v%0d_iresp_quiet", idx), bus.iresp_data_ok, 0);
    end else begin
      chk($sformatf("v%0d_iresp_ok", idx), {bus.iresp_addr_ok, bus.iresp_data_ok}, 2'b11);
      chk($sformatf("v%0d_iresp_data", idx), bus.iresp_data, v.exp_rdata[31:0]);
      chk($sformatf("v%0d_dresp_quiet", idx), bus.dresp_data_ok, 0);
    end
    tick();
    bus.mresp_data_ok = 1'b0;
    bus.ireq_valid    = 1'b0;
    bus.dreq_valid    = 1'b0;
    #1;
    chk($sformatf("v%0d_back_to_idle", idx), bus.mreq_valid, 0);
    chk($sformatf("v%0d_single_pulse", idx), {bus.iresp_data_ok, bus.dresp_data_ok}, 0);
  endtask

  logic exp_seq_d[10];
  logic got_d;

  initial begin
    vecs[0] = '{iv:1'b1, ia:64'h8000_0000, dv:1'b1, da:64'h1000, dsz:3'd3, dstb:8'h00,
                dd:64'h55, mdata:64'hAAAA_BBBB_CCCC_DDDD, wait_cyc:0,
                exp_d:1'b1, exp_wr:1'b0, exp_addr:64'h1000, exp_size:3'd3, exp_strb:8'h00,
                exp_data:64'h55, exp_rdata:64'hAAAA_BBBB_CCCC_DDDD};
    vecs[1] = '{iv:1'b1, ia:64'h8000_0000, dv:1'b0, da:64'h0, dsz:3'd7, dstb:8'hFF,
                dd:64'hFFFF, mdata:64'h1111_2222_3333_4444, wait_cyc:1,
                exp_d:1'b0, exp_wr:1'b0, exp_addr:64'h8000_0000, exp_size:3'b010, exp_strb:8'h00,
                exp_data:64'h0, exp_rdata:64'h3333_4444};
    vecs[2] = '{iv:1'b1, ia:64'h8000_0004, dv:1'b0, da:64'h0, dsz:3'd0, dstb:8'h00,
                dd:64'h0, mdata:64'h1111_2222_3333_4444, wait_cyc:0,
                exp_d:1'b0, exp_wr:1'b0, exp_addr:64'h8000_0004, exp_size:3'b010, exp_strb:8'h00,
                exp_data:64'h0, exp_rdata:64'h1111_2222};
    vecs[3] = '{iv:1'b0, ia:64'h0, dv:1'b1, da:64'h2000, dsz:3'd2, dstb:8'h0F,
                dd:64'hDEAD_BEEF, mdata:64'h0, wait_cyc:5,
                exp_d:1'b1, exp_wr:1'b1, exp_addr:64'h2000, exp_size:3'd2, exp_strb:8'h0F,
                exp_data:64'hDEAD_BEEF, exp_rdata:64'h0};
    vecs[4] = '{iv:1'b0, ia:64'h0, dv:1'b1, da:64'h2007, dsz:3'd0, dstb:8'h80,
                dd:64'hAB00_0000_0000_0000, mdata:64'h0123_4567_89AB_CDEF, wait_cyc:2,
                exp_d:1'b1, exp_wr:1'b1, exp_addr:64'h2007, exp_size:3'd0, exp_strb:8'h80,
                exp_data:64'hAB00_0000_0000_0000, exp_rdata:64'h0123_4567_89AB_CDEF};
    vecs[5] = '{iv:1'b1, ia:64'h0000_000C, dv:1'b0, da:64'h0, dsz:3'd3, dstb:8'h3C,
                dd:64'h1234, mdata:64'hFEDC_BA98_7654_3210, wait_cyc:3,
                exp_d:1'b0, exp_wr:1'b0, exp_addr:64'h0000_000C, exp_size:3'b010, exp_strb:8'h00,
                exp_data:64'h0, exp_rdata:64'hFEDC_BA98};

    for (int k = 0; k < 10; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_seq_d[k] = (k % 2 == 0);
`else
      exp_seq_d[k] = (k != 8);
`endif
    end

    // Reset: outputs stay quiet even with live requests and responses
    clear_inputs();
    reset = 1'b0;
    bus.ireq_valid    = 1'b1;
    bus.dreq_valid    = 1'b1;
    bus.mresp_data_ok = 1'b1;
    bus.mresp_data    = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    tick();
    chk("rst_mreq_valid", bus.mreq_valid, 0);
    chk("rst_mreq_addr", bus.mreq_addr, 0);
    chk("rst_data_ok", {bus.iresp_data_ok, bus.dresp_data_ok}, 0);
    chk("rst_dresp_data", bus.dresp_data, 0);
    clear_inputs();
    reset = 1'b1;

    for (int i = 0; i < 6; i++) run_txn(vecs[i], i);

    // Both requesters held: grant order over ten arbitrations
    bus.ireq_valid  = 1'b1;
    bus.ireq_addr   = 64'h9000_0000;
    bus.dreq_valid  = 1'b1;
    bus.dreq_addr   = 64'h3000;
    bus.dreq_strobe = 8'h00;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("arb%0d_mreq_valid", k), bus.mreq_valid, 1);
      got_d = (bus.mreq_addr == 64'h3000);
      chk($sformatf("arb%0d_grant_is_d", k), got_d, exp_seq_d[k]);
      bus.mresp_data_ok = 1'b1;
      tick();
      bus.mresp_data_ok = 1'b0;
    end
    clear_inputs();

    // ibus drops valid mid-transaction; response still pulses
    bus.ireq_valid = 1'b1;
    bus.ireq_addr  = 64'h40;
    tick();
    chk("drop_busy", bus.mreq_valid, 1);
    bus.ireq_valid = 1'b0;
    tick();
    tick();
    bus.mresp_data    = 64'h7777_8888_9999_AAAA;
    bus.mresp_data_ok = 1'b1;
    #1;
    chk("drop_iresp_ok", bus.iresp_data_ok, 1);
    chk("drop_iresp_data", bus.iresp_data, 64'h9999_AAAA);
    tick();
    bus.mresp_data_ok = 1'b0;
    #1;
    chk("drop_idle", bus.mreq_valid, 0);

    // Stray response while idle is ignored
    bus.mresp_data_ok = 1'b1;
    #1;
    chk("stray_ok_quiet", {bus.iresp_data_ok, bus.dresp_data_ok}, 0);
    tick();
    chk("stray_stays_idle", bus.mreq_valid, 0);
    bus.mresp_data_ok = 1'b0;

    // Reset during BUSY_D abandons the transaction
    bus.dreq_valid = 1'b1;
    bus.dreq_addr  = 64'h5000;
    tick();
    chk("rstd_busy", bus.mreq_valid, 1);
    bus.dreq_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("rstd_mreq_valid_now", bus.mreq_valid, 0);
    chk("rstd_mreq_addr", bus.mreq_addr, 0);
    bus.mresp_data_ok = 1'b1;
    #1;
    chk("rstd_no_dresp", bus.dresp_data_ok, 0);
    tick();
    bus.dreq_valid = 1'b1;
    bus.dreq_addr  = 64'h6000;
    reset = 1'b1;
    #1;
    chk("rstd_no_dresp_after", bus.dresp_data_ok, 0);
    bus.mresp_data_ok = 1'b0;
    tick();
    chk("rstd_first_arb", bus.mreq_valid, 1);
    chk("rstd_first_addr", bus.mreq_addr, 64'h6000);
    bus.dreq_valid    = 1'b0;
    bus.mresp_data_ok = 1'b1;
    #1;
    chk("rstd_new_dresp", bus.dresp_data_ok, 1);
    tick();
    clear_inputs();
    #1;
    chk("rstd_final_idle", bus.mreq_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/idbus_arbiter.md
IDBUS_ARBITER -- requirements
Module: idbus_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8, meaning max consecutive dbus grants while ibus waits (fixed-priority mode only).
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports ireq_valid in 1, ireq_addr in 64: instruction fetch request, held until iresp_data_ok.
REQ-005 SHALL have ports iresp_addr_ok out 1, iresp_data_ok out 1, iresp_data out 32: instruction response.
REQ-006 SHALL have ports dreq_valid in 1, dreq_addr in 64, dreq_size in 3, dreq_strobe in 8, dreq_data in 64: data request; strobe!=0 means write.
REQ-007 SHALL have ports dresp_addr_ok out 1, dresp_data_ok out 1, dresp_data out 64: data response.
REQ-008 SHALL have ports mreq_valid out 1, mreq_is_write out 1, mreq_addr out 64, mreq_size out 3, mreq_strobe out 8, mreq_data out 64: shared memory-bus request.
REQ-009 SHALL have ports mresp_data_ok in 1, mresp_data in 64: shared memory-bus response.

Function
REQ-010 SHALL implement FSM states IDLE, BUSY_I, BUSY_D.
REQ-011 IDLE: if any requester valid, SHALL pick winner (REQ-014), latch its request fields into internal registers, move to BUSY_I/BUSY_D next edge.
REQ-012 BUSY_x: mreq_valid=1 and mreq_* driven from latched registers only; fields SHALL stay stable until mresp_data_ok.
REQ-013 Latency: request sampled in IDLE at cycle N -> mreq_valid=1 in cycle N+1; min two cycles per transaction including IDLE.
REQ-014 Default arbitration: dbus wins over ibus; starvation counter increments per dbus grant while ireq_valid=1, clears on ibus grant; when counter==STARVE_LIMIT, ibus wins next arbitration.
REQ-015 Ibus fetch: mreq_is_write=0, mreq_size=3'b010 (4 bytes), mreq_strobe=0, mreq_data=0; iresp_data=mresp_data[31:0] if ireq_addr[2]==0 else mresp_data[63:32].
REQ-016 Dbus: mreq_is_write=(dreq_strobe!=0); size/strobe/data passed from latch; dresp_data=mresp_data.
REQ-017 In BUSY_I, iresp_data_ok=iresp_addr_ok=mresp_data_ok (combinational same cycle); dbus outputs 0; symmetric for BUSY_D.
REQ-018 On mresp_data_ok SHALL return to IDLE next edge; no back-to-back grant in same cycle.
REQ-019 Requester not granted SHALL see addr_ok=data_ok=0 and keep waiting.
REQ-020 Requester dropping valid mid-transaction: transaction SHALL still complete and data_ok still pulse; requester discards it.
REQ-021 mresp_data_ok in IDLE SHALL be ignored; no output pulse.
REQ-022 Starvation counter SHALL saturate at STARVE_LIMIT, never wrap.

Reset
REQ-023 reset low SHALL asynchronously force IDLE, clear latched fields, starvation counter, rr pointer; all outputs 0.
REQ-024 Reset mid-transaction SHALL abandon it; no data_ok pulse after release; first arbitration on first edge after release.

Configuration
REQ-025 ARB_ROUND_ROBIN_EN defined: arbitration SHALL alternate via 1-bit last-grant pointer (tie -> side not last granted; first tie after reset -> dbus); starvation counter and STARVE_LIMIT unused.
REQ-026 ARB_ROUND_ROBIN_EN undefined: fixed dbus priority with starvation limit per REQ-014.

Structure
REQ-027 arb_state_t enum and MEM_SIZE_WORD constant SHALL live in shared package common; request/response fields map to existing ibus/dbus struct members at core level.
REQ-028 One sub-module arb_pick (combinational winner select, including rr/starvation logic) SHALL be instantiated; FSM and latches stay in idbus_arbiter.

Verification
REQ-029 Both valid in IDLE, counter 0 (fixed mode) -> dbus granted, mreq_addr=dreq_addr; after its data_ok, next grant to ibus if dbus drops valid.
REQ-030 dreq_valid held continuously, ireq_valid=1, STARVE_LIMIT=8 -> 8 dbus grants then ibus granted on 9th arbitration.
REQ-031 ibus fetch addr 0x8000_0004, mresp_data=0x1111_2222_3333_4444 -> iresp_data=0x1111_2222, single-cycle data_ok.
REQ-032 dbus write strobe 8'h0F, data 0xDEAD_BEEF, mresp_data_ok after 5 cycles -> mreq_is_write=1, fields stable all 5 cycles, dresp_data_ok one cycle.
REQ-033 reset asserted during BUSY_D -> mreq_valid=0 immediately; no dresp_data_ok after release.
REQ-034 ARB_ROUND_ROBIN_EN, both valid continuously -> grants d, i, d, i in that order.
